// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared constants, FSM state type and byte-placement helper for the
//   SHA-256 message padder (sha256_padder) and its block buffer
//   (sha256_blk_buf).
//   No ports; imported with "import sha256_pkg::*;".
package sha256_pkg;

  localparam int BLK_W     = 512;
  localparam int WORD_W    = 32;
  localparam int LEN_W     = 64;
  localparam int BLK_BYTES = 64;

  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int         LEN_POS  = 56;

  // Fixed trailer of the second hash in double-SHA256: a 256-bit message,
  // so word 8 holds the pad marker and word 15 the 256-bit length.
  localparam logic [WORD_W-1:0] DBL_WORD8  = 32'h8000_0000;
  localparam logic [WORD_W-1:0] DBL_WORD15 = 32'h0000_0100;

  typedef enum logic [2:0] {
    ST_ABSORB     = 3'd0,
    ST_PAD        = 3'd1,
    ST_EMIT_DATA  = 3'd2,
    ST_EMIT_SPILL = 3'd3,
    ST_EMIT_FINAL = 3'd4
  } pad_state_e;

  // Bit offset of message byte idx inside a block: word idx/4, big-endian
  // within the word. 32*(idx/4) + 8*(3 - idx%4) equals this concatenation
  // because 3 - b == ~b for a 2-bit b.
  function automatic logic [8:0] byte_lsb(input logic [5:0] idx);
    return {idx[5:2], ~idx[1:0], 3'b000};
  endfunction

endpackage

// File: rtl/sha256_blk_buf.sv
// sha256_blk_buf
//   64-byte block assembly buffer. Operations in one cycle are applied in
//   this order: clear, whole-block load, byte write at ptr, pad (0x80 at
//   ptr, zero every byte above ptr), length write into bytes 56..63.
// Ports:
//   clk, rst_n   clock, async active-low reset (buffer resets to zero)
//   clear        zero the whole buffer
//   load_en      replace the buffer with load_data
//   wr_en        write wr_byte at byte ptr
//   pad_en       write PAD_BYTE at ptr, zero bytes ptr+1..63
//   len_en       write len_val big-endian into bytes 56..63
//   ptr          byte pointer 0..63
//   data         buffer contents in block layout
module sha256_blk_buf
  import sha256_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load_en,
  input  logic             wr_en,
  input  logic             pad_en,
  input  logic             len_en,
  input  logic [5:0]       ptr,
  input  logic [7:0]       wr_byte,
  input  logic [LEN_W-1:0] len_val,
  input  logic [BLK_W-1:0] load_data,
  output logic [BLK_W-1:0] data
);

  logic [7:0] mem_q [BLK_BYTES];
  logic [7:0] mem_d [BLK_BYTES];

  always_comb begin
    for (int k = 0; k < BLK_BYTES; k++) begin
      mem_d[k] = clear ? 8'h00 : mem_q[k];
      if (load_en) mem_d[k] = load_data[byte_lsb(6'(k)) +: 8];
      if (wr_en && (ptr == 6'(k))) mem_d[k] = wr_byte;
      if (pad_en) begin
        if (ptr == 6'(k))     mem_d[k] = PAD_BYTE;
        else if (6'(k) > ptr) mem_d[k] = 8'h00;
      end
      // Byte 56 carries the most significant length byte.
      if (len_en && (k >= LEN_POS)) mem_d[k] = len_val[8*(BLK_BYTES-1-k) +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < BLK_BYTES; k++) mem_q[k] <= 8'h00;
    end else begin
      for (int k = 0; k < BLK_BYTES; k++) mem_q[k] <= mem_d[k];
    end
  end

  always_comb begin
    data = '0;
    for (int k = 0; k < BLK_BYTES; k++) data[byte_lsb(6'(k)) +: 8] = mem_q[k];
  end

endmodule

// File: rtl/sha256_padder.sv
// sha256_padder
//   Byte-stream front end for the SHA-256 core. Absorbs message bytes,
//   appends 0x80, zero fill and the 64-bit big-endian bit length, and
//   hands out 512-bit blocks (word j at blk_data[32j+31:32j]).
//   Optional build macro SHA256_PADDER_DBL_EN adds dig_data/dig_valid: a
//   256-bit digest is wrapped into the single padded block of the second
//   hash of double-SHA256.
// Handshakes: a transfer happens on a rising clk edge where valid && ready
//   are both high. blk_valid, blk_data, blk_first and blk_last stay stable
//   until blk_ready; in_data/in_last must be held while in_ready is low.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_data/in_valid/in_last/in_ready   byte input stream
//   blk_data/blk_valid/blk_ready        block output
//   blk_first             first block of a message (core reloads IV)
//   blk_last              final block of a message
//   dig_data/dig_valid    digest input (SHA256_PADDER_DBL_EN only)
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [BLK_W-1:0] blk_data,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic             blk_first,
  output logic             blk_last
`ifdef SHA256_PADDER_DBL_EN
  ,
  input  logic [255:0]     dig_data,
  input  logic             dig_valid
`endif
);

  pad_state_e        state_q, state_d;
  logic [6:0]        p_q, p_d;          // 0..64; 64 means the block is full
  logic [CNT_W-1:0]  cnt_q, cnt_d;      // message bytes, wraps silently
  logic              first_q, first_d;
  logic              pad_done_q, pad_done_d; // 0x80 already placed

  logic              buf_clear, buf_load, buf_wr, buf_pad, buf_len;
  logic [5:0]        buf_ptr;
  logic [LEN_W-1:0]  len_bits;
  logic [BLK_W-1:0]  load_data;
  logic              dig_take;

  assign len_bits = LEN_W'(cnt_q) << 3;

`ifdef SHA256_PADDER_DBL_EN
  assign load_data = {DBL_WORD15, {6{32'h0}}, DBL_WORD8, dig_data};
`else
  assign load_data = '0;
`endif

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    pad_done_d = pad_done_q;
    buf_clear  = 1'b0;
    buf_load   = 1'b0;
    buf_wr     = 1'b0;
    buf_pad    = 1'b0;
    buf_len    = 1'b0;
    buf_ptr    = p_q[5:0];
    in_ready   = 1'b0;
    dig_take   = 1'b0;
`ifdef SHA256_PADDER_DBL_EN
    dig_take   = (state_q == ST_ABSORB) && (p_q == '0) && dig_valid;
`endif

    case (state_q)
      ST_ABSORB: begin
        if (dig_take) begin
          // Digest wins over a pending byte; in_ready stays low this cycle.
          buf_load = 1'b1;
          first_d  = 1'b1;
          state_d  = ST_EMIT_FINAL;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            buf_wr = 1'b1;
            p_d    = p_q + 7'd1;
            cnt_d  = cnt_q + 1'b1;
            if (in_last)             state_d = ST_PAD;
            else if (p_q == 7'd63)   state_d = ST_EMIT_DATA;
          end
        end
      end

      ST_PAD: begin
        // p_q == 64: the message filled the block; it goes out unchanged
        // and the marker moves to the spill block.
        buf_pad    = ~p_q[6];
        pad_done_d = ~p_q[6];
        if (p_q < 7'(LEN_POS)) begin
          buf_len = 1'b1;
          state_d = ST_EMIT_FINAL;
        end else begin
          state_d = ST_EMIT_SPILL;
        end
      end

      ST_EMIT_DATA: begin
        if (blk_ready) begin
          buf_clear = 1'b1;
          p_d       = '0;
          first_d   = 1'b0;
          state_d   = ST_ABSORB;
        end
      end

      ST_EMIT_SPILL: begin
        if (blk_ready) begin
          buf_clear = 1'b1;
          buf_ptr   = 6'd0;
          buf_pad   = ~pad_done_q;
          buf_len   = 1'b1;
          first_d   = 1'b0;
          state_d   = ST_EMIT_FINAL;
        end
      end

      ST_EMIT_FINAL: begin
        if (blk_ready) begin
          buf_clear  = 1'b1;
          p_d        = '0;
          cnt_d      = '0;
          first_d    = 1'b1;
          pad_done_d = 1'b0;
          state_d    = ST_ABSORB;
        end
      end

      default: state_d = ST_ABSORB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ABSORB;
      p_q        <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b1;
      pad_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      pad_done_q <= pad_done_d;
    end
  end

  assign blk_valid = (state_q == ST_EMIT_DATA) || (state_q == ST_EMIT_SPILL) ||
                     (state_q == ST_EMIT_FINAL);
  assign blk_first = blk_valid && first_q;
  assign blk_last  = (state_q == ST_EMIT_FINAL);

  sha256_blk_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (buf_clear),
    .load_en   (buf_load),
    .wr_en     (buf_wr),
    .pad_en    (buf_pad),
    .len_en    (buf_len),
    .ptr       (buf_ptr),
    .wr_byte   (in_data),
    .len_val   (len_bits),
    .load_data (load_data),
    .data      (blk_data)
  );

endmodule
